// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the VeriRISC CPU.
//   - Opcode codes (IR[7:5]). The same numeric codes double as the ALU
//     operation selects (PASS0=HLT, PASS1=SKZ, ADD, AND, XOR, PASSB=LDA).
//   - Instruction-cycle phase encoding used by the controller.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int PHASE_WIDTH  = 3;

    localparam logic [OPCODE_WIDTH-1:0] HLT = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] ADD = 3'd2;
    localparam logic [OPCODE_WIDTH-1:0] AND = 3'd3;
    localparam logic [OPCODE_WIDTH-1:0] XOR = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] LDA = 3'd5;
    localparam logic [OPCODE_WIDTH-1:0] STO = 3'd6;
    localparam logic [OPCODE_WIDTH-1:0] JMP = 3'd7;

    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Instructions whose result goes through the ALU into the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller_phase_counter.sv
// phase_counter: 8-phase instruction-cycle counter.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, forces INST_ADDR
//   hold  in   freeze the current phase (used while the CPU is halted)
//   phase out  current phase, wraps STORE -> INST_ADDR
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    output phase_t phase
);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= INST_ADDR;
        end else if (!hold) begin
            phase <= phase_t'(phase + PHASE_WIDTH'(1));
        end
    end

endmodule

// File: rtl/controller.sv
// controller: sequencing FSM of the VeriRISC CPU.
// Steps through an 8-phase instruction cycle and decodes the current phase,
// opcode, ALU zero flag and halted flag into the datapath strobes.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (clears phase and halt)
//   opcode in   IR[7:5]
//   zero   in   ALU accumulator-is-zero flag
//   sel    out  address mux select: 1=PC, 0=IR operand
//   rd     out  memory read enable
//   ld_ir  out  load instruction register
//   inc_pc out  increment program counter
//   halt   out  CPU halted / halting
//   ld_pc  out  load PC from IR operand
//   data_e out  drive accumulator onto data bus
//   ld_ac  out  load accumulator from ALU
//   wr     out  memory write enable
module controller
    import cpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    halt,
    output logic                    ld_pc,
    output logic                    data_e,
    output logic                    ld_ac,
    output logic                    wr
);

    phase_t phase;
    logic   halted;
    logic   halt_set;
    logic   aluop;

    // Halting happens at the edge that leaves OP_ADDR with HLT in the IR; the
    // phase must not advance on that same edge so it freezes at OP_ADDR.
    assign halt_set = (phase == OP_ADDR) && (opcode == HLT);

    phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (halted || halt_set),
        .phase (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (halt_set) begin
            halted <= 1'b1;
        end
    end

    assign aluop = is_aluop(opcode);

    // Opcode and zero are only referenced inside the phase 4-7 branches so
    // that an unsettled IR during fetch cannot disturb the strobes.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;

        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    inc_pc = (opcode == JMP);
                    data_e = (opcode == STO);
                    wr     = (opcode == STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed instruction cycles plus randomized traffic,
// checked by a scoreboard against a behavioural model of the instruction cycle.
module tb_controller;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

    controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] val;   // {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
        int         ph;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int mphase  = 0;
    bit mhalted = 1'b0;
    bit known   = 1'b0;

    // Expected strobes derived directly from the instruction-cycle table.
    function automatic logic [8:0] exp_out(input int ph, input bit hl,
                                           input logic [2:0] op, input logic z);
        logic s, r, li, ip, h, lp, de, la, w;
        bit alu;
        s = 0; r = 0; li = 0; ip = 0; h = 0; lp = 0; de = 0; la = 0; w = 0;
        if (hl) begin
            h = 1;
        end else if (ph < 4) begin
            s  = 1;
            r  = (ph >= 1);
            li = (ph >= 2);
        end else begin
            alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
            ip  = (ph == 4) || (ph == 6 && op == SKZ && z == 1'b1) || (ph == 7 && op == JMP);
            h   = (ph == 4) && (op == HLT);
            r   = (ph >= 5) && alu;
            la  = (ph >= 6) && alu;
            lp  = (ph >= 6) && (op == JMP);
            de  = (ph >= 6) && (op == STO);
            w   = (ph == 7) && (op == STO);
        end
        return {s, r, li, ip, h, lp, de, la, w};
    endfunction

    task automatic step(input bit r, input logic [2:0] op, input logic z, input string tag);
        exp_t e;
        rst    = r;
        opcode = op;
        zero   = z;
        if (known) begin
            e.val = exp_out(mphase, mhalted, op, z);
            e.ph  = mphase;
            e.tag = tag;
            q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            mphase  = 0;
            mhalted = 1'b0;
            known   = 1'b1;
        end else if (known && !mhalted) begin
            if (mphase == 4 && op == HLT) mhalted = 1'b1;
            else mphase = (mphase + 1) % 8;
        end
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic z, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, op, z, tag);
    endtask

    // Monitor: outputs are combinational and always present; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if ({sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} !== e.val) begin
                bad++;
                $display("FAIL %s phase=%0d got=%b want=%b (sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr)",
                         e.tag, e.ph, {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}, e.val);
            end
        end
    end

    initial begin
        logic [2:0] rop;
        logic       rz;
        bit         rr;

        // Reset held for two clocks
        step(1'b1, ADD, 1'b0, "reset");
        step(1'b1, ADD, 1'b0, "reset");

        run(ADD, 1'b0, 8, "add");
        run(SKZ, 1'b1, 8, "skz_z1");
        run(SKZ, 1'b0, 8, "skz_z0");
        run(JMP, 1'b0, 8, "jmp");
        run(STO, 1'b1, 8, "sto");

        // Halt, stay halted for 10 clocks, then recover through reset
        run(HLT, 1'b0, 5, "hlt");
        run(HLT, 1'b0, 10, "halted");
        run(ADD, 1'b1, 3, "halted_other");
        step(1'b1, ADD, 1'b0, "hlt_rst");
        run(ADD, 1'b0, 8, "after_hlt");

        // Reset in ALU_OP of an ADD
        run(ADD, 1'b0, 6, "add_pre");
        step(1'b1, ADD, 1'b0, "mid_rst");
        run(ADD, 1'b0, 8, "add_restart");

        // Randomized traffic, X on opcode/zero during fetch phases
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 39) == 0);
            rop = 3'($urandom_range(0, 7));
            if (rop == HLT && $urandom_range(0, 2) != 0) rop = 3'($urandom_range(1, 7));
            rz  = 1'($urandom_range(0, 1));
            if (!mhalted && mphase < 4 && $urandom_range(0, 2) == 0) begin
                rop = 3'bxxx;
                rz  = 1'bx;
            end
            step(rr, rop, rz, "random");
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
